ram_stream_reader: RTL and testbench

- Read-side initiator for the synchronous dual-port RAM. Given a start address and byte count, it issues RAM reads and absorbs the RAM's 1-cycle read latency.
- Delivers each word on a valid/ready stream to the UART transmitter.
- Sits between the message buffer RAM and uart_tx; the TX path uses it to drain buffered data.

---
 rtl/ram_stream_reader.sv | 125 ++++++++++++
 tb/tb_ram_stream_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Reads a run of words from a synchronous RAM and streams them out on valid/ready.
// Optional LOOP_EN: adds a loop input that replays the same run until it is dropped.
module ram_stream_reader #(
  parameter  int WIDTH_MEM = 8,
  parameter  int DEPTH_MEM = 16,
  localparam int AW        = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        start_addr,
  input  logic [AW:0]          length,
`ifdef LOOP_EN
  input  logic                 loop,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 rd_enable,
  output logic [AW-1:0]        rd_address,
  input  logic [WIDTH_MEM-1:0] rd_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH_MEM-1:0] m_data
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH_MEM);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH_MEM - 1);

  logic [1:0]           state_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 m_valid_reg;
  logic [AW-1:0]        rd_address_reg;
  logic [WIDTH_MEM-1:0] m_data_reg;
  logic [AW:0]          remaining_reg;
  logic [AW-1:0]        start_addr_reg;
  logic [AW:0]          length_reg;
  logic [AW:0]          length_clamped;
  logic [AW-1:0]        addr_next;
  logic                 loop_now;

`ifdef LOOP_EN
  assign loop_now = loop;
`else
  assign loop_now = 1'b0;
`endif

  assign length_clamped = (length > DEPTH_L) ? DEPTH_L : length;
  // Non-power-of-two depths need the explicit wrap rather than natural overflow.
  assign addr_next      = (rd_address_reg == LAST_A) ? '0 : rd_address_reg + 1'b1;

  assign rd_enable  = (state_reg == S_ISSUE);
  assign rd_address = rd_address_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign m_valid    = m_valid_reg;
  assign m_data     = m_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      m_valid_reg    <= 1'b0;
      rd_address_reg <= '0;
      m_data_reg     <= '0;
      remaining_reg  <= '0;
      start_addr_reg <= '0;
      length_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (length_clamped == '0) begin
              done_reg <= 1'b1;
            end else begin
              rd_address_reg <= start_addr;
              remaining_reg  <= length_clamped;
              start_addr_reg <= start_addr;
              length_reg     <= length_clamped;
              busy_reg       <= 1'b1;
              state_reg      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state_reg <= S_CAPTURE;
        end
        S_CAPTURE: begin
          m_data_reg  <= rd_data;
          m_valid_reg <= 1'b1;
          state_reg   <= S_HOLD;
        end
        S_HOLD: begin
          if (m_ready) begin
            m_valid_reg <= 1'b0;
            if (remaining_reg != (AW+1)'(1)) begin
              rd_address_reg <= addr_next;
              remaining_reg  <= remaining_reg - 1'b1;
              state_reg      <= S_ISSUE;
            end else if (loop_now) begin
              rd_address_reg <= start_addr_reg;
              remaining_reg  <= length_reg;
              state_reg      <= S_ISSUE;
            end else begin
              rd_address_reg <= addr_next;
              remaining_reg  <= '0;
              busy_reg       <= 1'b0;
              done_reg       <= 1'b1;
              state_reg      <= S_IDLE;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: a model RAM feeds the DUT, expected
// addresses and words are queued at command time and popped as the DUT produces them.
module tb_ram_stream_reader;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, rd_enable, m_valid;
  logic [AW-1:0] rd_address;
  logic [W-1:0]  rd_data = '0;
  logic [W-1:0]  m_data;
  logic          m_ready = 1'b0;
`ifdef LOOP_EN
  logic          loop = 1'b0;
`endif

  ram_stream_reader #(.WIDTH_MEM(W), .DEPTH_MEM(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
`ifdef LOOP_EN
    .loop(loop),
`endif
    .busy(busy), .done(done), .rd_enable(rd_enable), .rd_address(rd_address),
    .rd_data(rd_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [D];
  always @(posedge clk) if (rd_enable) rd_data <= mem[rd_address];

  int checks = 0;
  int errors = 0;
  int rden_cnt = 0, done_cnt = 0, hs_cnt = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit prev_stall = 0;
  logic [W-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: one line per transaction, scoreboard compare on reads and handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (rd_enable) begin
        rden_cnt++;
        if (exp_addr.size() == 0) chk("unexpected_rden", 32'(rd_address), 32'hDEAD);
        else chk("rd_addr", 32'(rd_address), exp_addr.pop_front());
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        $display("word %0d data=%02h", hs_cnt, m_data);
        if (exp_data.size() == 0) chk("unexpected_word", 32'(m_data), 32'hDEAD);
        else chk("m_data", 32'(m_data), exp_data.pop_front());
      end
      if (done) done_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic start_cmd(input int addr, input int len, input bit now);
    int n;
    if (!now) begin @(posedge clk); #1; end
    start = 1'b1; start_addr = AW'(addr); length = (AW+1)'(len);
    n = (len > D) ? D : len;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(32'((addr + i) % D));
      exp_data.push_back(32'(mem[(addr + i) % D]));
    end
    @(posedge clk); #1;
    start = 1'b0;
    $display("cmd addr=%0d len=%0d", addr, len);
    chk("accept_busy", 32'(busy), 32'(len != 0));
  endtask

  task automatic wait_done(input int max, output int cycles);
    bit seen = 0;
    cycles = 0;
    while (cycles < max && !seen) begin
      @(posedge clk); #1;
      cycles++;
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int max);
    int c = 0;
    while (c < max && !m_valid) begin @(posedge clk); #1; c++; end
    if (!m_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic queues_empty(input string tag);
    chk({tag, "_addrq"}, 32'(exp_addr.size()), 32'd0);
    chk({tag, "_dataq"}, 32'(exp_data.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, r0, d0, h0;
    for (int i = 0; i < D; i++) mem[i] = 8'(8'h10 + i);
    mem[3] = 8'h41; mem[4] = 8'h42; mem[5] = 8'h43;
    mem[14] = 8'hA0; mem[15] = 8'hA1; mem[0] = 8'hA2; mem[1] = 8'hA3;

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rden", 32'(rd_enable), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_addr", 32'(rd_address), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic run with latency and throughput.
    m_ready = 1'b1;
    r0 = rden_cnt;
    start_cmd(3, 3, 0);
    chk("t1_rden_issue", 32'(rd_enable), 32'd1);
    chk("t1_addr_issue", 32'(rd_address), 32'd3);
    @(posedge clk); #1;
    chk("t1_valid_e1", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_valid_e2", 32'(m_valid), 32'd1);
    wait_done(50, cyc);
    chk("t1_done_cycle", 32'(cyc), 32'd7);
    chk("t1_busy_at_done", 32'(busy), 32'd0);
    chk("t1_rden_count", 32'(rden_cnt - r0), 32'd3);
    queues_empty("t1");

    // Wrap, started in the done cycle of the previous command.
    d0 = done_cnt;
    start_cmd(14, 4, 1);
    wait_done(60, cyc);
    queues_empty("wrap");

    // Clamp to full depth, with a start pulsed mid-transfer.
    r0 = rden_cnt;
    start_cmd(0, 20, 0);
    repeat (6) @(posedge clk);
    #1 start = 1'b1; start_addr = 4'd7; length = 5'd2;
    @(posedge clk); #1 start = 1'b0;
    chk("mid_start_busy", 32'(busy), 32'd1);
    wait_done(100, cyc);
    chk("clamp_rden_count", 32'(rden_cnt - r0), 32'd16);
    queues_empty("clamp");

    // Zero length.
    r0 = rden_cnt;
    start_cmd(5, 0, 0);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_rden", 32'(rd_enable), 32'd0);
    @(posedge clk); #1;
    chk("len0_done_pulse", 32'(done), 32'd0);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_rden_count", 32'(rden_cnt - r0), 32'd0);

    // Back-pressure.
    m_ready = 1'b0;
    start_cmd(3, 3, 0);
    wait_valid(20);
    r0 = rden_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_no_rden", 32'(rden_cnt - r0), 32'd0);
    chk("bp_valid_held", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    wait_done(50, cyc);
    queues_empty("bp");

    // Reset during HOLD of word 2 of 4.
    for (int i = 8; i < 12; i++) mem[i] = 8'(8'hC0 + i);
    m_ready = 1'b0;
    start_cmd(8, 4, 0);
    wait_valid(20);
    m_ready = 1'b1;
    @(posedge clk); #1 m_ready = 1'b0;
    wait_valid(20);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_rden", 32'(rd_enable), 32'd0);
    chk("arst_addr", 32'(rd_address), 32'd0);
    chk("arst_data", 32'(m_data), 32'd0);
    exp_addr.delete();
    exp_data.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_no_done", 32'(done_cnt - d0), 32'd0);
    m_ready = 1'b1;
    start_cmd(3, 3, 0);
    wait_done(50, cyc);
    queues_empty("post_rst");

`ifdef LOOP_EN
    // Looping replay, then a normal finish once loop is dropped.
    mem[0] = 8'h55; mem[1] = 8'h66;
    loop = 1'b1;
    d0 = done_cnt;
    h0 = hs_cnt;
    start_cmd(0, 2, 0);
    start_cmd(0, 2, 1);  // accepted only as scoreboard entries; DUT is busy
    for (int i = 0; i < 2; i++) begin
      exp_addr.push_back(32'(i));
      exp_data.push_back(32'(mem[i]));
    end
    cyc = 0;
    while (hs_cnt - h0 < 4 && cyc < 60) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    loop = 1'b0;
    chk("loop_busy", 32'(busy), 32'd1);
    chk("loop_no_done", 32'(done_cnt - d0), 32'd0);
    wait_done(60, cyc);
    @(posedge clk); #1;
    chk("loop_words", 32'(hs_cnt - h0), 32'd6);
    chk("loop_one_done", 32'(done_cnt - d0), 32'd1);
    queues_empty("loop");
`else
    h0 = hs_cnt;
    d0 = done_cnt;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_valid", 32'(m_valid), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
